// File: rtl/pl_stim_sequencer.sv
// pl_stim_sequencer: holds a DUT in reset, then replays a programmed table of
// switch patterns with per-step delays and checks the DUT outputs against
// masked expected values at the end of every step.
// Optional build macro STIM_FIRSTFAIL_EN adds a first-failure capture port set
// (first_fail_vld / first_fail_idx / first_fail_obs).
module pl_stim_sequencer #(
   parameter int NUM_SW    = 4,
   parameter int OBS_W     = 52,
   parameter int DEPTH     = 16,
   parameter int DLY_W     = 16,
   parameter int RESET_CYC = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int TW = DLY_W + NUM_SW + 2 * OBS_W
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              tbl_we,
   input  logic [AW-1:0]     tbl_addr,
   input  logic [TW-1:0]     tbl_wdata,
   input  logic [AW:0]       num_steps,
   input  logic              start,
   input  logic [OBS_W-1:0]  obs_in,
   output logic              dut_resetn,
   output logic [NUM_SW-1:0] sw_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_count,
   output logic [AW-1:0]     step_idx
`ifdef STIM_FIRSTFAIL_EN
   ,
   output logic              first_fail_vld,
   output logic [AW-1:0]     first_fail_idx,
   output logic [OBS_W-1:0]  first_fail_obs
`endif
);

   localparam int RC_W = $clog2(RESET_CYC) + 1;
   localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RESET_CYC - 1);
   localparam logic [AW:0]      DEPTH_S = (AW + 1)'(DEPTH);
   localparam logic [AW:0]      ONE_S   = (AW + 1)'(1);
   localparam logic [DLY_W-1:0] ONE_D   = DLY_W'(1);

   typedef enum logic [2:0] {
      IDLE,
      RST_HOLD,
      APPLY,
      WAIT,
      CHECK,
      DONE
   } state_t;

   state_t state;

   // Stimulus table; intentionally not reset so a run can be repeated after resetn
   logic [TW-1:0] tbl [DEPTH];

   logic [AW:0]        steps_lat;
   logic [DLY_W-1:0]   dly_cnt;
   logic [RC_W-1:0]    rst_cnt;

   logic [TW-1:0]      cur_entry;
   logic [DLY_W-1:0]   cur_dly;
   logic [NUM_SW-1:0]  cur_sw;
   logic [OBS_W-1:0]   cur_exp;
   logic [OBS_W-1:0]   cur_mask;
   logic               mismatch;
   logic               last_step;
   logic               table_open;
   logic [7:0]         err_inc;

   assign cur_entry  = tbl[step_idx];
   assign cur_dly    = cur_entry[TW-1 -: DLY_W];
   assign cur_sw     = cur_entry[2*OBS_W +: NUM_SW];
   assign cur_exp    = cur_entry[OBS_W +: OBS_W];
   assign cur_mask   = cur_entry[0 +: OBS_W];
   assign mismatch   = |((obs_in ^ cur_exp) & cur_mask);
   assign last_step  = (({1'b0, step_idx} + ONE_S) == steps_lat);
   assign table_open = (state == IDLE) || (state == DONE);
   assign err_inc    = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

   // Table writes are only accepted while no run is in progress
   always_ff @(posedge clock) begin
      if (tbl_we && table_open) begin
         tbl[tbl_addr] <= tbl_wdata;
      end
   end

   // Run sequencer: reset hold, then apply/wait/check for each programmed step
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state          <= IDLE;
         dut_resetn     <= 1'b0;
         sw_out         <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         step_idx       <= '0;
         steps_lat      <= '0;
         dly_cnt        <= '0;
         rst_cnt        <= '0;
`ifdef STIM_FIRSTFAIL_EN
         first_fail_vld <= 1'b0;
         first_fail_idx <= '0;
         first_fail_obs <= '0;
`endif
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  steps_lat      <= (num_steps > DEPTH_S) ? DEPTH_S : num_steps;
                  err_count      <= '0;
                  step_idx       <= '0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  dut_resetn     <= 1'b0;
                  sw_out         <= '0;
                  rst_cnt        <= '0;
`ifdef STIM_FIRSTFAIL_EN
                  first_fail_vld <= 1'b0;
                  first_fail_idx <= '0;
                  first_fail_obs <= '0;
`endif
                  state          <= RST_HOLD;
               end
            end
            RST_HOLD: begin
               dut_resetn <= 1'b0;
               sw_out     <= '0;
               if (rst_cnt == RC_LAST) begin
                  dut_resetn <= 1'b1;
                  if (steps_lat == '0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= APPLY;
                  end
               end else begin
                  rst_cnt <= rst_cnt + 1'b1;
               end
            end
            APPLY: begin
               sw_out  <= cur_sw;
               dly_cnt <= (cur_dly == '0) ? ONE_D : cur_dly;
               state   <= WAIT;
            end
            WAIT: begin
               if (dly_cnt == ONE_D) begin
                  state <= CHECK;
               end else begin
                  dly_cnt <= dly_cnt - ONE_D;
               end
            end
            CHECK: begin
               if (mismatch) begin
                  err_count <= err_inc;
`ifdef STIM_FIRSTFAIL_EN
                  if (!first_fail_vld) begin
                     first_fail_vld <= 1'b1;
                     first_fail_idx <= step_idx;
                     first_fail_obs <= obs_in;
                  end
`endif
               end
               if (last_step) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == 8'd0);
                  state <= DONE;
               end else begin
                  step_idx <= step_idx + 1'b1;
                  state    <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pl_stim_sequencer.sv
// tb_pl_stim_sequencer: directed table-driven runs plus randomized programs
// checked against a step-level reference model of the sequencer.
module tb_pl_stim_sequencer;

   localparam int NUM_SW    = 4;
   localparam int OBS_W     = 52;
   localparam int DEPTH     = 16;
   localparam int DLY_W     = 16;
   localparam int RESET_CYC = 8;
   localparam int AW        = 4;
   localparam int TW        = DLY_W + NUM_SW + 2 * OBS_W;
   localparam int SDEPTH    = 512;
   localparam int SAW       = 9;

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              tbl_we = 1'b0;
   logic [AW-1:0]     tbl_addr = '0;
   logic [TW-1:0]     tbl_wdata = '0;
   logic [AW:0]       num_steps = '0;
   logic              start = 1'b0;
   logic [OBS_W-1:0]  obs_in;
   logic              dut_resetn;
   logic [NUM_SW-1:0] sw_out;
   logic              busy, done, pass;
   logic [7:0]        err_count;
   logic [AW-1:0]     step_idx;

   logic              s_tbl_we = 1'b0;
   logic [SAW-1:0]    s_tbl_addr = '0;
   logic [TW-1:0]     s_tbl_wdata = '0;
   logic [SAW:0]      s_num_steps = '0;
   logic              s_start = 1'b0;
   logic [OBS_W-1:0]  s_obs_in = '0;
   logic              s_dut_resetn;
   logic [NUM_SW-1:0] s_sw_out;
   logic              s_busy, s_done, s_pass;
   logic [7:0]        s_err_count;
   logic [SAW-1:0]    s_step_idx;

`ifdef STIM_FIRSTFAIL_EN
   logic              ff_vld, s_ff_vld;
   logic [AW-1:0]     ff_idx;
   logic [SAW-1:0]    s_ff_idx;
   logic [OBS_W-1:0]  ff_obs, s_ff_obs;
`endif

   logic [OBS_W-1:0]  obs_arr [DEPTH];
   assign obs_in = obs_arr[step_idx];

   pl_stim_sequencer #(
      .NUM_SW(NUM_SW), .OBS_W(OBS_W), .DEPTH(DEPTH), .DLY_W(DLY_W), .RESET_CYC(RESET_CYC)
   ) dut (
      .clock(clock), .resetn(resetn), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
      .tbl_wdata(tbl_wdata), .num_steps(num_steps), .start(start), .obs_in(obs_in),
      .dut_resetn(dut_resetn), .sw_out(sw_out), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .step_idx(step_idx)
`ifdef STIM_FIRSTFAIL_EN
      , .first_fail_vld(ff_vld), .first_fail_idx(ff_idx), .first_fail_obs(ff_obs)
`endif
   );

   // Large-depth instance used only to reach error-count saturation within one run
   pl_stim_sequencer #(
      .NUM_SW(NUM_SW), .OBS_W(OBS_W), .DEPTH(SDEPTH), .DLY_W(DLY_W), .RESET_CYC(RESET_CYC)
   ) dut_sat (
      .clock(clock), .resetn(resetn), .tbl_we(s_tbl_we), .tbl_addr(s_tbl_addr),
      .tbl_wdata(s_tbl_wdata), .num_steps(s_num_steps), .start(s_start), .obs_in(s_obs_in),
      .dut_resetn(s_dut_resetn), .sw_out(s_sw_out), .busy(s_busy), .done(s_done),
      .pass(s_pass), .err_count(s_err_count), .step_idx(s_step_idx)
`ifdef STIM_FIRSTFAIL_EN
      , .first_fail_vld(s_ff_vld), .first_fail_idx(s_ff_idx), .first_fail_obs(s_ff_obs)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cyc = -1;

   // Free-running cycle counter used to timestamp output events
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: record switch changes seen by the DUT and the cycle done rises
   int               chg_cyc [$];
   logic [NUM_SW-1:0] chg_val [$];
   logic [NUM_SW-1:0] last_sw = '0;
   logic              last_done = 1'b0;
   always @(negedge clock) begin
      if (sw_out !== last_sw && dut_resetn === 1'b1) begin
         chg_cyc.push_back(cyc);
         chg_val.push_back(sw_out);
      end
      last_sw = sw_out;
      if (done && !last_done) done_cyc = cyc;
      last_done = done;
   end

   // Monitor: the saturating error count must never decrease during a run
   logic       sat_wrap = 1'b0;
   logic [7:0] last_err_s = '0;
   always @(negedge clock) begin
      if (s_busy && (s_err_count < last_err_s)) sat_wrap = 1'b1;
      last_err_s = s_err_count;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic write_entry(input int addr, input int d, input logic [3:0] sw,
                              input logic [OBS_W-1:0] ex, input logic [OBS_W-1:0] mk);
      @(negedge clock);
      tbl_we    = 1'b1;
      tbl_addr  = addr[AW-1:0];
      tbl_wdata = {d[DLY_W-1:0], sw, ex, mk};
      @(negedge clock);
      tbl_we    = 1'b0;
   endtask

   task automatic applyStimulus(input int n);
      @(negedge clock);
      num_steps = n[AW:0];
      start     = 1'b1;
      chg_cyc.delete();
      chg_val.delete();
      done_cyc  = -1;
      @(negedge clock);
      start     = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic wait_done(input int budget, input string name);
      int k;
      k = 0;
      while (!done && k < budget) begin
         @(negedge clock);
         k++;
      end
      checkOutput({name, "_done"}, {63'd0, done}, 64'd1);
      @(negedge clock);
   endtask

   function automatic logic [NUM_SW-1:0] chg_at(input int i);
      return (i < chg_val.size()) ? chg_val[i] : '0;
   endfunction

   function automatic int chg_cyc_at(input int i);
      return (i < chg_cyc.size()) ? chg_cyc[i] : -1;
   endfunction

   typedef struct {
      int               dly;
      logic [NUM_SW-1:0] sw;
      int               step_len;
   } step_vec_t;

   step_vec_t        t2v [3];
   int               rdl [DEPTH];
   logic [NUM_SW-1:0] rsw [DEPTH];
   logic [OBS_W-1:0] rex [DEPTH];
   logic [OBS_W-1:0] rmk [DEPTH];
   logic [OBS_W-1:0] ones;

   initial begin
      int exp_c, exp_done, k, lowcnt, n, neff, m_err, m_lat, m_ff;

      t2v[0] = '{dly: 5, sw: 4'h1, step_len: 6};
      t2v[1] = '{dly: 0, sw: 4'h3, step_len: 2};
      t2v[2] = '{dly: 2, sw: 4'hF, step_len: 3};
      ones = '1;
      for (int i = 0; i < DEPTH; i++) obs_arr[i] = '0;

      // Reset values
      repeat (3) @(negedge clock);
      checkOutput("rst_dut_resetn", {63'd0, dut_resetn}, 64'd0);
      checkOutput("rst_sw_out", {60'd0, sw_out}, 64'd0);
      checkOutput("rst_busy", {63'd0, busy}, 64'd0);
      checkOutput("rst_done", {63'd0, done}, 64'd0);
      checkOutput("rst_pass", {63'd0, pass}, 64'd0);
      checkOutput("rst_err", {56'd0, err_count}, 64'd0);
      checkOutput("rst_step", {60'd0, step_idx}, 64'd0);
      resetn = 1'b1;

      // T1: resetn low in the middle of WAIT of step index 1, then rerun from retained table
      write_entry(0, 4, 4'hA, '0, '0);
      write_entry(1, 9, 4'hB, '0, '0);
      write_entry(2, 3, 4'hC, '0, '0);
      applyStimulus(3);
      k = 0;
      while (!(step_idx == 4'd1 && sw_out == 4'hB) && k < 200) begin
         @(negedge clock);
         k++;
      end
      checkOutput("t1_reached_step1", {63'd0, (k < 200)}, 64'd1);
      repeat (2) @(negedge clock);
      resetn = 1'b0;
      #1;
      checkOutput("t1_dut_resetn", {63'd0, dut_resetn}, 64'd0);
      checkOutput("t1_sw_out", {60'd0, sw_out}, 64'd0);
      checkOutput("t1_busy", {63'd0, busy}, 64'd0);
      checkOutput("t1_err", {56'd0, err_count}, 64'd0);
      checkOutput("t1_step", {60'd0, step_idx}, 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      checkOutput("t1_idle_busy", {63'd0, busy}, 64'd0);
      applyStimulus(3);
      wait_done(100, "t1_rerun");
      checkOutput("t1_rerun_sw0", {60'd0, chg_at(0)}, 64'hA);
      checkOutput("t1_rerun_sw1", {60'd0, chg_at(1)}, 64'hB);
      checkOutput("t1_rerun_sw2", {60'd0, chg_at(2)}, 64'hC);
      checkOutput("t1_rerun_lat", 64'(done_cyc - start_cyc), 64'd30);

      // T2: three-step table with matching observations
      for (int i = 0; i < 3; i++) begin
         obs_arr[i] = OBS_W'({$urandom(), $urandom()});
         write_entry(i, t2v[i].dly, t2v[i].sw, obs_arr[i], ones);
      end
      applyStimulus(3);
      wait_done(100, "t2");
      checkOutput("t2_nchg", 64'(chg_val.size()), 64'd3);
      exp_c = RESET_CYC + 1;
      exp_done = RESET_CYC;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("t2_sw%0d", i), {60'd0, chg_at(i)}, {60'd0, t2v[i].sw});
         checkOutput($sformatf("t2_when%0d", i), 64'(chg_cyc_at(i) - start_cyc), 64'(exp_c));
         exp_c    += t2v[i].step_len + 1;
         exp_done += t2v[i].step_len + 1;
      end
      checkOutput("t2_lat", 64'(done_cyc - start_cyc), 64'(exp_done));
      checkOutput("t2_pass", {63'd0, pass}, 64'd1);
      checkOutput("t2_err", {56'd0, err_count}, 64'd0);
      checkOutput("t2_busy", {63'd0, busy}, 64'd0);

      // T3: single masked mismatch on step 1
      for (int i = 0; i < DEPTH; i++) obs_arr[i] = '0;
      write_entry(0, 1, 4'h1, '1, '0);
      write_entry(1, 1, 4'h2, OBS_W'(1), OBS_W'(1));
      write_entry(2, 1, 4'h3, '1, '0);
      applyStimulus(3);
      wait_done(100, "t3");
      checkOutput("t3_err", {56'd0, err_count}, 64'd1);
      checkOutput("t3_pass", {63'd0, pass}, 64'd0);
`ifdef STIM_FIRSTFAIL_EN
      checkOutput("t3_ff_vld", {63'd0, ff_vld}, 64'd1);
      checkOutput("t3_ff_idx", {60'd0, ff_idx}, 64'd1);
      checkOutput("t3_ff_obs", {12'd0, ff_obs}, 64'd0);
`endif

      // T4: zero steps only pulses the DUT reset
      applyStimulus(0);
      lowcnt = 0;
      k = 0;
      while (!done && k < 50) begin
         if (!dut_resetn) lowcnt++;
         @(negedge clock);
         k++;
      end
      checkOutput("t4_low_cycles", 64'(lowcnt), 64'(RESET_CYC));
      checkOutput("t4_done", {63'd0, done}, 64'd1);
      checkOutput("t4_pass", {63'd0, pass}, 64'd1);
      checkOutput("t4_sw_out", {60'd0, sw_out}, 64'd0);
      checkOutput("t4_dut_resetn", {63'd0, dut_resetn}, 64'd1);

      // T5: start and table write while busy are ignored
      write_entry(0, 6, 4'h5, '0, '0);
      write_entry(1, 6, 4'h6, '0, '0);
      applyStimulus(2);
      repeat (3) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      write_entry(0, 1, 4'h9, '0, '0);
      checkOutput("t5_busy", {63'd0, busy}, 64'd1);
      wait_done(100, "t5");
      checkOutput("t5_lat", 64'(done_cyc - start_cyc), 64'(RESET_CYC + 16));
      checkOutput("t5_sw0", {60'd0, chg_at(0)}, 64'h5);
      checkOutput("t5_sw1", {60'd0, chg_at(1)}, 64'h6);
      applyStimulus(1);
      wait_done(100, "t5_rerun");
      checkOutput("t5_table_kept", {60'd0, chg_at(0)}, 64'h5);

      // Randomized programs against a step-level model
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < DEPTH; i++) begin
            rdl[i] = $urandom_range(0, 6);
            rsw[i] = NUM_SW'($urandom());
            rex[i] = OBS_W'({$urandom(), $urandom()});
            obs_arr[i] = ($urandom_range(0, 1) == 1) ? rex[i]
                         : rex[i] ^ (OBS_W'(1) << $urandom_range(0, OBS_W - 1));
            case ($urandom_range(0, 2))
               0:       rmk[i] = '0;
               1:       rmk[i] = '1;
               default: rmk[i] = OBS_W'({$urandom(), $urandom()});
            endcase
            write_entry(i, rdl[i], rsw[i], rex[i], rmk[i]);
         end
         n = (r == 5) ? 20 : (r == 4) ? 16 : $urandom_range(1, 15);
         neff = (n > DEPTH) ? DEPTH : n;
         m_err = 0;
         m_lat = RESET_CYC;
         m_ff = -1;
         for (int i = 0; i < neff; i++) begin
            m_lat += ((rdl[i] == 0) ? 1 : rdl[i]) + 2;
            if (((obs_arr[i] ^ rex[i]) & rmk[i]) != '0) begin
               if (m_err < 255) m_err++;
               if (m_ff < 0) m_ff = i;
            end
         end
         applyStimulus(n);
         wait_done(m_lat + 50, $sformatf("rnd%0d", r));
         checkOutput($sformatf("rnd%0d_lat", r), 64'(done_cyc - start_cyc), 64'(m_lat));
         checkOutput($sformatf("rnd%0d_err", r), {56'd0, err_count}, 64'(m_err));
         checkOutput($sformatf("rnd%0d_pass", r), {63'd0, pass}, 64'(m_err == 0));
         checkOutput($sformatf("rnd%0d_sw", r), {60'd0, sw_out}, {60'd0, rsw[neff-1]});
         checkOutput($sformatf("rnd%0d_step", r), {60'd0, step_idx}, 64'(neff - 1));
`ifdef STIM_FIRSTFAIL_EN
         checkOutput($sformatf("rnd%0d_ff_vld", r), {63'd0, ff_vld}, 64'(m_ff >= 0));
         if (m_ff >= 0) begin
            checkOutput($sformatf("rnd%0d_ff_idx", r), {60'd0, ff_idx}, 64'(m_ff));
            checkOutput($sformatf("rnd%0d_ff_obs", r), {12'd0, ff_obs}, {12'd0, obs_arr[m_ff]});
         end
`endif
      end

      // T6: 300 failing steps on the deep instance saturate the error count
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         s_tbl_we    = 1'b1;
         s_tbl_addr  = SAW'(i);
         s_tbl_wdata = {16'd0, NUM_SW'(i), ones, ones};
      end
      @(negedge clock);
      s_tbl_we    = 1'b0;
      s_num_steps = 10'd300;
      s_start     = 1'b1;
      @(negedge clock);
      s_start     = 1'b0;
      k = 0;
      while (!s_done && k < 2000) begin
         @(negedge clock);
         k++;
      end
      checkOutput("t6_done", {63'd0, s_done}, 64'd1);
      checkOutput("t6_err_sat", {56'd0, s_err_count}, 64'd255);
      checkOutput("t6_pass", {63'd0, s_pass}, 64'd0);
      checkOutput("t6_no_wrap", {63'd0, sat_wrap}, 64'd0);
      checkOutput("t6_step", {55'd0, s_step_idx}, 64'd299);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
